// File: rtl/quadrilatero_pkg.sv
`default_nettype none
// ============================================================================
// Module      : quadrilatero_pkg
// Description : Shared constants and types for the quadrilatero MAC arbiter.
//               Holds the FP32 operand width, the requester-ID type (sized for
//               the largest supported requester count) and the round-robin
//               pointer advance helper.
// Revision    : 1.0 - initial release
// ============================================================================
package quadrilatero_pkg;

    localparam int FP32_W      = 32;
    localparam int NUM_REQ_MAX = 16;
    localparam int REQ_ID_W    = $clog2(NUM_REQ_MAX);

    typedef logic [REQ_ID_W-1:0] req_id_t;
    typedef logic [FP32_W-1:0]   fp32_t;

    // Advance a round-robin pointer past `id`, wrapping after n-1.
    function automatic req_id_t rr_next(input req_id_t id, input int n);
        if (int'(id) + 1 >= n) begin
            return '0;
        end
        return id + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/quadrilatero_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : quadrilatero_tag_fifo
// Description : Small synchronous FIFO holding the requester IDs of operations
//               currently inside the MAC. A pop and a push in the same cycle
//               are accepted even when full (the pop frees the slot).
// Ports       : clk_i, rst_i   - clock, synchronous active-high reset
//               push_i, data_i - write request and ID to store
//               pop_i          - remove the head entry (ignored when empty)
//               full_o, empty_o, head_o - status and oldest entry
// Revision    : 1.0 - initial release
// ============================================================================
module quadrilatero_tag_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int             PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             CNT_W    = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign head_o    = mem_q[rd_ptr_q];
    assign w_do_pop  = pop_i & ~empty_o;
    // A simultaneous pop frees the slot the push needs.
    assign w_do_push = push_i & (~full_o | w_do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (w_do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/quadrilatero_mac_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : quadrilatero_mac_arbiter
// Description : Round-robin arbiter sharing one pipelined FP32 MAC among
//               NUM_REQ requesters. Grants issue to the MAC in the same cycle;
//               the granted requester ID is queued and results are routed back
//               in issue order, one cycle after mac_finished_i.
// Ports       : clk_i, rst_i                      - clock, sync active-high reset
//               req_valid_i / req_ready_o          - per-requester handshake
//               req_data_i/weight_i/acc_i          - packed NUM_REQ x 32 operands
//               mac_valid_o, mac_*_o               - issue to the MAC
//               mac_finished_i, mac_acc_i          - MAC result
//               resp_valid_o, resp_acc_o           - registered result return
//               busy_o, err_o                      - in-flight / sticky orphan result
//               grant_cnt_o, stall_cnt_o           - saturating statistics
// Config      : define QUADRILATERO_MAC_ARB_STATS_EN to build the statistics
//               counters; otherwise both counter ports read 0.
// Revision    : 1.0 - initial release
// ============================================================================
module quadrilatero_mac_arbiter
    import quadrilatero_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MAC_LATENCY = 2,
    parameter int TAG_DEPTH   = MAC_LATENCY + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*FP32_W-1:0] req_data_i,
    input  logic [NUM_REQ*FP32_W-1:0] req_weight_i,
    input  logic [NUM_REQ*FP32_W-1:0] req_acc_i,
    output logic                      mac_valid_o,
    output logic [FP32_W-1:0]         mac_data_o,
    output logic [FP32_W-1:0]         mac_weight_o,
    output logic [FP32_W-1:0]         mac_acc_o,
    input  logic                      mac_finished_i,
    input  logic [FP32_W-1:0]         mac_acc_i,
    output logic [NUM_REQ-1:0]        resp_valid_o,
    output logic [FP32_W-1:0]         resp_acc_o,
    output logic                      busy_o,
    output logic                      err_o,
    output logic [31:0]               grant_cnt_o,
    output logic [31:0]               stall_cnt_o
);

    logic               w_found;
    logic               w_grant;
    logic               w_pop;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    req_id_t            w_winner;
    req_id_t            w_head;
    req_id_t            rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    fp32_t              resp_acc_q, resp_acc_d;
    logic               err_q, err_d;

    // A result arriving with nothing in flight is an orphan: flagged, not popped.
    assign w_pop   = mac_finished_i & ~w_fifo_empty;
    // Full is tolerated when the head leaves this same cycle.
    assign w_grant = w_found & ~rst_i & (~w_fifo_full | w_pop);

    // Round-robin search starting at rr_ptr_q, wrapping.
    always_comb begin
        int cand;
        w_found  = 1'b0;
        w_winner = '0;
        cand     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!w_found && req_valid_i[cand]) begin
                w_found  = 1'b1;
                w_winner = req_id_t'(cand);
            end
        end
    end

    // Zero-cycle issue: operands of the winner go straight to the MAC.
    always_comb begin
        mac_valid_o  = w_grant;
        mac_data_o   = '0;
        mac_weight_o = '0;
        mac_acc_o    = '0;
        req_ready_o  = '0;
        if (w_grant) begin
            mac_data_o   = req_data_i[int'(w_winner)*FP32_W +: FP32_W];
            mac_weight_o = req_weight_i[int'(w_winner)*FP32_W +: FP32_W];
            mac_acc_o    = req_acc_i[int'(w_winner)*FP32_W +: FP32_W];
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready_o[i] = w_grant && (w_winner == req_id_t'(i));
        end
    end

    always_comb begin
        rr_ptr_d     = w_grant ? rr_next(w_winner, NUM_REQ) : rr_ptr_q;
        resp_valid_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid_d[i] = w_pop && (w_head == req_id_t'(i));
        end
        resp_acc_d   = w_pop ? mac_acc_i : resp_acc_q;
        err_d        = err_q | (mac_finished_i & w_fifo_empty);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q     <= '0;
            resp_valid_q <= '0;
            resp_acc_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_acc_q   <= resp_acc_d;
            err_q        <= err_d;
        end
    end

    quadrilatero_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .WIDTH (REQ_ID_W)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_grant),
        .data_i  (w_winner),
        .pop_i   (w_pop),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .head_o  (w_head)
    );

    assign resp_valid_o = resp_valid_q;
    assign resp_acc_o   = resp_acc_q;
    assign busy_o       = ~w_fifo_empty;
    assign err_o        = err_q;

`ifdef QUADRILATERO_MAC_ARB_STATS_EN
    logic [31:0] grant_cnt_q, grant_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Both counters saturate at all-ones.
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (w_grant && (grant_cnt_q != '1)) begin
            grant_cnt_d = grant_cnt_q + 1'b1;
        end
        if ((|req_valid_i) && !w_grant && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign grant_cnt_o = grant_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    assign grant_cnt_o = '0;
    assign stall_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_quadrilatero_mac_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_quadrilatero_mac_arbiter
// Description : Directed self-checking bench for quadrilatero_mac_arbiter.
//               dut  : default parameters, driven by a 2-stage stand-in MAC.
//               dut2 : TAG_DEPTH=2, mac_finished_i driven directly.
//               Build with QUADRILATERO_MAC_ARB_STATS_EN to check counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quadrilatero_mac_arbiter;

    localparam int NUM_REQ = 4;

    // Requester operand sets; requester 2 carries 1.0, 2.0, 3.0.
    localparam logic [31:0] D_TAB [4] = '{32'h0000_0011, 32'h1000_0000, 32'h3F80_0000, 32'hFFFF_0000};
    localparam logic [31:0] W_TAB [4] = '{32'h0000_2200, 32'h0200_0000, 32'h4000_0000, 32'h0000_FFFF};
    localparam logic [31:0] A_TAB [4] = '{32'h0033_0000, 32'h0000_0003, 32'h4040_0000, 32'h0F0F_0F0F};
    // Stand-in MAC results: xor of operands, except 1.0*2.0+3.0 = 5.0.
    localparam logic [31:0] R_TAB [4] = '{32'h0033_2211, 32'h1200_0003, 32'h40A0_0000, 32'hF0F0_F0F0};

    // dut2 directed scenario, one entry per cycle.
    localparam logic        D2_VAL [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic        D2_FIN [11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic [3:0]  D2_RDY [11] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000,
                                           4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    localparam logic [3:0]  D2_RSP [11] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                           4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0001};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    logic [NUM_REQ*32-1:0] req_data, req_weight, req_acc;

    // ---------------- dut ----------------
    logic               rst = 1'b1;
    logic [NUM_REQ-1:0] req_valid = '0;
    logic [NUM_REQ-1:0] req_ready, resp_valid;
    logic               mac_valid, mac_fin, busy, err;
    logic [31:0]        mac_data, mac_weight, mac_acc, mac_res, resp_acc, grant_cnt, stall_cnt;
    logic               force_fin = 1'b0;
    logic [31:0]        force_acc = '0;

    quadrilatero_mac_arbiter #(.NUM_REQ(NUM_REQ), .MAC_LATENCY(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_data_i(req_data), .req_weight_i(req_weight), .req_acc_i(req_acc),
        .mac_valid_o(mac_valid), .mac_data_o(mac_data), .mac_weight_o(mac_weight), .mac_acc_o(mac_acc),
        .mac_finished_i(mac_fin), .mac_acc_i(mac_res),
        .resp_valid_o(resp_valid), .resp_acc_o(resp_acc),
        .busy_o(busy), .err_o(err),
        .grant_cnt_o(grant_cnt), .stall_cnt_o(stall_cnt)
    );

    function automatic logic [31:0] mac_model(input logic [31:0] d, input logic [31:0] w, input logic [31:0] a);
        if (d == 32'h3F80_0000 && w == 32'h4000_0000 && a == 32'h4040_0000) return 32'h40A0_0000;
        return d ^ w ^ a;
    endfunction

    // Two-stage stand-in MAC; deliberately not reset so late results can appear.
    logic [1:0]  pv  = '0;
    logic [31:0] pr0 = '0;
    logic [31:0] pr1 = '0;
    always @(posedge clk) begin
        pv  <= {pv[0], mac_valid};
        pr0 <= mac_model(mac_data, mac_weight, mac_acc);
        pr1 <= pr0;
    end
    assign mac_fin = pv[1] | force_fin;
    assign mac_res = pv[1] ? pr1 : force_acc;

    // ---------------- dut2 ----------------
    logic               rst2 = 1'b1;
    logic [NUM_REQ-1:0] req_valid2 = '0;
    logic [NUM_REQ-1:0] req_ready2, resp_valid2;
    logic               mac_valid2, busy2, err2;
    logic [31:0]        mac_data2, mac_weight2, mac_acc2, resp_acc2, grant_cnt2, stall_cnt2;
    logic               fin2 = 1'b0;
    logic [31:0]        res2 = '0;

    quadrilatero_mac_arbiter #(.NUM_REQ(NUM_REQ), .MAC_LATENCY(2), .TAG_DEPTH(2)) dut2 (
        .clk_i(clk), .rst_i(rst2),
        .req_valid_i(req_valid2), .req_ready_o(req_ready2),
        .req_data_i(req_data), .req_weight_i(req_weight), .req_acc_i(req_acc),
        .mac_valid_o(mac_valid2), .mac_data_o(mac_data2), .mac_weight_o(mac_weight2), .mac_acc_o(mac_acc2),
        .mac_finished_i(fin2), .mac_acc_i(res2),
        .resp_valid_o(resp_valid2), .resp_acc_o(resp_acc2),
        .busy_o(busy2), .err_o(err2),
        .grant_cnt_o(grant_cnt2), .stall_cnt_o(stall_cnt2)
    );

    task automatic do_reset;
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 4'hF;
        #1;
        vec_cnt++; if (req_ready !== 4'b0000) begin miss_cnt++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
        vec_cnt++; if (mac_valid !== 1'b0) begin miss_cnt++; $display("FAIL rst_mac_valid: got %b want 0", mac_valid); end
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        #1;
        vec_cnt++; if (resp_valid !== 4'b0000) begin miss_cnt++; $display("FAIL rst_resp_valid: got %b want 0000", resp_valid); end
        vec_cnt++; if (resp_acc !== 32'h0) begin miss_cnt++; $display("FAIL rst_resp_acc: got %h want 0", resp_acc); end
        vec_cnt++; if (err !== 1'b0) begin miss_cnt++; $display("FAIL rst_err: got %b want 0", err); end
        vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL rst_busy: got %b want 0", busy); end
        vec_cnt++; if (grant_cnt !== 32'h0 || stall_cnt !== 32'h0) begin
            miss_cnt++; $display("FAIL rst_counters: got %h/%h want 0/0", grant_cnt, stall_cnt);
        end
    endtask

    task automatic test_single;
        @(negedge clk);
        req_valid = 4'b0100;
        #1;
        vec_cnt++; if (req_ready !== 4'b0100) begin miss_cnt++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        vec_cnt++; if (mac_valid !== 1'b1) begin miss_cnt++; $display("FAIL single_mac_valid: got %b want 1", mac_valid); end
        vec_cnt++; if ({mac_data, mac_weight, mac_acc} !== {32'h3F80_0000, 32'h4000_0000, 32'h4040_0000}) begin
            miss_cnt++; $display("FAIL single_operands: got %h %h %h want 3f800000 40000000 40400000", mac_data, mac_weight, mac_acc);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        vec_cnt++; if (mac_valid !== 1'b0 || mac_data !== 32'h0) begin
            miss_cnt++; $display("FAIL idle_mac: got valid=%b data=%h want 0/0", mac_valid, mac_data);
        end
        vec_cnt++; if (busy !== 1'b1) begin miss_cnt++; $display("FAIL single_busy: got %b want 1", busy); end
        @(negedge clk);
        #1;
        vec_cnt++; if (resp_valid !== 4'b0000) begin miss_cnt++; $display("FAIL single_early_resp: got %b want 0000", resp_valid); end
        @(negedge clk);
        #1;
        vec_cnt++; if (resp_valid !== 4'b0100) begin miss_cnt++; $display("FAIL single_resp_valid: got %b want 0100", resp_valid); end
        vec_cnt++; if (resp_acc !== 32'h40A0_0000) begin miss_cnt++; $display("FAIL single_resp_acc: got %h want 40a00000", resp_acc); end
        @(negedge clk);
        #1;
        vec_cnt++; if (resp_valid !== 4'b0000 || busy !== 1'b0) begin
            miss_cnt++; $display("FAIL single_done: got resp=%b busy=%b want 0000/0", resp_valid, busy);
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_v;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            if (c > 0) @(negedge clk);
            req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            if (c < 8) begin
                exp_v = 4'b0001 << (c % 4);
                vec_cnt++; if (req_ready !== exp_v) begin
                    miss_cnt++; $display("FAIL rr_grant c%0d: got %b want %b", c, req_ready, exp_v);
                end
                vec_cnt++; if (mac_data !== D_TAB[c % 4]) begin
                    miss_cnt++; $display("FAIL rr_mac_data c%0d: got %h want %h", c, mac_data, D_TAB[c % 4]);
                end
            end
            exp_v = (c >= 3) ? (4'b0001 << ((c - 3) % 4)) : 4'b0000;
            vec_cnt++; if (resp_valid !== exp_v) begin
                miss_cnt++; $display("FAIL rr_resp_valid c%0d: got %b want %b", c, resp_valid, exp_v);
            end
            if (c >= 3) begin
                vec_cnt++; if (resp_acc !== R_TAB[(c - 3) % 4]) begin
                    miss_cnt++; $display("FAIL rr_resp_acc c%0d: got %h want %h", c, resp_acc, R_TAB[(c - 3) % 4]);
                end
            end
        end
        @(negedge clk);
        #1;
        vec_cnt++; if (busy !== 1'b0 || resp_valid !== 4'b0000) begin
            miss_cnt++; $display("FAIL rr_drain: got busy=%b resp=%b want 0/0000", busy, resp_valid);
        end
    endtask

    task automatic test_empty_finish;
        @(negedge clk);
        force_fin = 1'b1;
        force_acc = 32'hDEAD_BEEF;
        @(negedge clk);
        force_fin = 1'b0;
        #1;
        vec_cnt++; if (err !== 1'b1) begin miss_cnt++; $display("FAIL orphan_err: got %b want 1", err); end
        vec_cnt++; if (resp_valid !== 4'b0000) begin miss_cnt++; $display("FAIL orphan_resp: got %b want 0000", resp_valid); end
        @(negedge clk);
        @(negedge clk);
        #1;
        vec_cnt++; if (err !== 1'b1 || resp_valid !== 4'b0000) begin
            miss_cnt++; $display("FAIL orphan_sticky: got err=%b resp=%b want 1/0000", err, resp_valid);
        end
        do_reset();
        #1;
        vec_cnt++; if (err !== 1'b0) begin miss_cnt++; $display("FAIL orphan_clear: got %b want 0", err); end
    endtask

    task automatic test_reset_inflight;
        do_reset();
        req_valid = 4'b0010;
        #1;
        vec_cnt++; if (req_ready !== 4'b0010) begin miss_cnt++; $display("FAIL rif_grant0: got %b want 0010", req_ready); end
        @(negedge clk);
        #1;
        vec_cnt++; if (req_ready !== 4'b0010) begin miss_cnt++; $display("FAIL rif_grant1: got %b want 0010", req_ready); end
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 4'hF;
        #1;
        vec_cnt++; if (req_ready !== 4'b0000 || mac_valid !== 1'b0) begin
            miss_cnt++; $display("FAIL rif_in_reset: got ready=%b mac_valid=%b want 0000/0", req_ready, mac_valid);
        end
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        #1;
        vec_cnt++; if (busy !== 1'b0 || resp_valid !== 4'b0000 || err !== 1'b0) begin
            miss_cnt++; $display("FAIL rif_after_reset: got busy=%b resp=%b err=%b want 0/0000/0", busy, resp_valid, err);
        end
        @(negedge clk);
        req_valid = 4'hF;
        #1;
        vec_cnt++; if (err !== 1'b1) begin miss_cnt++; $display("FAIL rif_late_err: got %b want 1", err); end
        vec_cnt++; if (resp_valid !== 4'b0000) begin miss_cnt++; $display("FAIL rif_late_resp: got %b want 0000", resp_valid); end
        vec_cnt++; if (req_ready !== 4'b0001) begin miss_cnt++; $display("FAIL rif_rr_ptr: got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        vec_cnt++; if (resp_valid !== 4'b0001 || resp_acc !== R_TAB[0]) begin
            miss_cnt++; $display("FAIL rif_post_resp: got %b/%h want 0001/%h", resp_valid, resp_acc, R_TAB[0]);
        end
        do_reset();
    endtask

    task automatic test_full_fifo_stats;
        logic [31:0] exp_g, exp_s;
        logic [31:0] exp_acc;
`ifdef QUADRILATERO_MAC_ARB_STATS_EN
        exp_g = 32'd5;
        exp_s = 32'd3;
`else
        exp_g = 32'd0;
        exp_s = 32'd0;
`endif
        @(negedge clk);
        rst2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        for (int c = 0; c < 11; c++) begin
            if (c > 0) @(negedge clk);
            req_valid2 = D2_VAL[c] ? 4'hF : 4'h0;
            fin2       = D2_FIN[c];
            res2       = 32'hA000_0000 + 32'(c);
            #1;
            vec_cnt++; if (req_ready2 !== D2_RDY[c]) begin
                miss_cnt++; $display("FAIL full_ready c%0d: got %b want %b", c, req_ready2, D2_RDY[c]);
            end
            vec_cnt++; if (resp_valid2 !== D2_RSP[c]) begin
                miss_cnt++; $display("FAIL full_resp c%0d: got %b want %b", c, resp_valid2, D2_RSP[c]);
            end
            if (D2_RSP[c] != 4'b0000) begin
                exp_acc = 32'hA000_0000 + 32'(c - 1);
                vec_cnt++; if (resp_acc2 !== exp_acc) begin
                    miss_cnt++; $display("FAIL full_resp_acc c%0d: got %h want %h", c, resp_acc2, exp_acc);
                end
            end
            if (c == 8) begin
                vec_cnt++; if (grant_cnt2 !== exp_g) begin
                    miss_cnt++; $display("FAIL stats_grant: got %0d want %0d", grant_cnt2, exp_g);
                end
                vec_cnt++; if (stall_cnt2 !== exp_s) begin
                    miss_cnt++; $display("FAIL stats_stall: got %0d want %0d", stall_cnt2, exp_s);
                end
            end
        end
        @(negedge clk);
        fin2 = 1'b0;
        #1;
        vec_cnt++; if (busy2 !== 1'b0 || err2 !== 1'b0) begin
            miss_cnt++; $display("FAIL full_drain: got busy=%b err=%b want 0/0", busy2, err2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < NUM_REQ; r++) begin
            req_data[r*32 +: 32]   = D_TAB[r];
            req_weight[r*32 +: 32] = W_TAB[r];
            req_acc[r*32 +: 32]    = A_TAB[r];
        end
        test_reset();
        test_single();
        test_round_robin();
        test_empty_finish();
        test_reset_inflight();
        test_full_fifo_stats();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
`default_nettype wire
